pio_input_event_reporter: RTL and testbench



---
 rtl/pio_input_event_reporter.sv | 222 ++++++++++++++++++++++
 tb/tb_pio_input_event_reporter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_input_event_reporter.sv
// Key/switch synchroniser + debouncer and key-press event FIFO for the host-read PIOs.
// Define PIO_INPUT_SW_DEBOUNCE_EN to debounce the slide switches as well.
module pio_input_event_reporter #(
  parameter int NUM_KEYS        = 4,
  parameter int NUM_SW          = 18,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_CYCLES     = 50000,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n_i,
  input  logic [NUM_SW-1:0]   sw_i,
  input  logic [31:0]         host_ctrl_i,
  output logic [31:0]         status_o,
  output logic [31:0]         event_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = AW + 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [NW-1:0] DEPTH   = NW'(FIFO_DEPTH);

  logic [NUM_KEYS-1:0]         key_s1_q, key_s1_d;
  logic [NUM_KEYS-1:0]         key_s2_q, key_s2_d;
  logic [NUM_KEYS-1:0]         key_acc_q, key_acc_d;
  logic [NUM_KEYS-1:0]         key_prev_q, key_prev_d;
  logic [NUM_KEYS-1:0][CW-1:0] key_cnt_q, key_cnt_d;
  logic [NUM_SW-1:0]           sw_s1_q, sw_s1_d;
  logic [NUM_SW-1:0]           sw_s2_q, sw_s2_d;
  logic [NUM_SW-1:0]           sw_view;
  logic [TW-1:0]               tick_q, tick_d;
  logic [15:0]                 ts_q, ts_d;
  logic [5:0]                  seq_q, seq_d;
  logic                        ovf_q, ovf_d;
  logic [FIFO_DEPTH-1:0][25:0] mem_q, mem_d;
  logic [AW-1:0]               rd_q, rd_d;
  logic [AW-1:0]               wr_q, wr_d;
  logic [NW-1:0]               cnt_q, cnt_d;
  logic [1:0]                  host_q, host_d;
  logic [31:0]                 status_q, status_d;
  logic [31:0]                 event_q, event_d;

  logic [NUM_KEYS-1:0] press;
  logic [3:0]          mask4;
  logic [3:0]          keys4;
  logic [3:0]          cnt4;
  logic [17:0]         sw18;
  logic [25:0]         head;
  logic                pop_req;
  logic                flush;
  logic                full;
  logic                do_pop;
  logic                do_push;
  logic                unused_host;

  assign unused_host = ^host_ctrl_i[31:2];

  always_comb begin
    key_s1_d   = key_n_i;
    key_s2_d   = key_s1_q;
    sw_s1_d    = sw_i;
    sw_s2_d    = sw_s1_q;
    key_prev_d = key_acc_q;
    key_acc_d  = key_acc_q;
    key_cnt_d  = key_cnt_q;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (key_s2_q[k] == key_acc_q[k]) begin
        key_cnt_d[k] = '0;
      end else if (key_cnt_q[k] == DB_LAST) begin
        key_acc_d[k] = key_s2_q[k];
        key_cnt_d[k] = '0;
      end else begin
        key_cnt_d[k] = key_cnt_q[k] + 1'b1;
      end
    end
  end

`ifdef PIO_INPUT_SW_DEBOUNCE_EN
  logic [NUM_SW-1:0]         sw_acc_q, sw_acc_d;
  logic [NUM_SW-1:0][CW-1:0] sw_cnt_q, sw_cnt_d;

  always_comb begin
    sw_acc_d = sw_acc_q;
    sw_cnt_d = sw_cnt_q;
    for (int s = 0; s < NUM_SW; s++) begin
      if (sw_s2_q[s] == sw_acc_q[s]) begin
        sw_cnt_d[s] = '0;
      end else if (sw_cnt_q[s] == DB_LAST) begin
        sw_acc_d[s] = sw_s2_q[s];
        sw_cnt_d[s] = '0;
      end else begin
        sw_cnt_d[s] = sw_cnt_q[s] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_acc_q <= '0;
      sw_cnt_q <= '0;
    end else begin
      sw_acc_q <= sw_acc_d;
      sw_cnt_q <= sw_cnt_d;
    end
  end

  assign sw_view = sw_acc_q;
`else
  assign sw_view = sw_s2_q;
`endif

  // A press is a released->pressed transition of the accepted level.
  assign press   = key_prev_q & ~key_acc_q;
  assign pop_req = host_ctrl_i[0] ^ host_q[0];
  assign flush   = host_ctrl_i[1] & ~host_q[1];
  assign full    = (cnt_q == DEPTH);
  assign do_pop  = pop_req & (cnt_q != '0);
  assign do_push = (|press) & (~full | do_pop);
  assign head    = mem_q[rd_q];

  always_comb begin
    mask4 = '0;
    mask4[NUM_KEYS-1:0] = press;
    host_d = host_ctrl_i[1:0];
    tick_d = tick_q + 1'b1;
    ts_d   = ts_q;
    if (tick_q == TK_LAST) begin
      tick_d = '0;
      ts_d   = ts_q + 16'd1;
    end
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    seq_d = seq_q;
    ovf_d = ovf_q;
    // Flush beats any push or pop landing in the same cycle.
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (do_pop) begin
        rd_d = rd_q + 1'b1;
      end
      if (do_push) begin
        mem_d[wr_q] = {seq_q, mask4, ts_q};
        wr_d  = wr_q + 1'b1;
        seq_d = seq_q + 6'd1;
      end else if (|press) begin
        ovf_d = 1'b1;
      end
      cnt_d = cnt_q + NW'(do_push) - NW'(do_pop);
    end
  end

  always_comb begin
    keys4 = '0;
    keys4[NUM_KEYS-1:0] = ~key_acc_q;
    cnt4 = '0;
    cnt4[NW-1:0] = cnt_q;
    sw18 = '0;
    sw18[NUM_SW-1:0] = sw_view;
    status_d = {keys4, cnt4, ovf_q, 5'b0, sw18};
    if (cnt_q != '0) begin
      event_d = {1'b1, ovf_q, head[25:20], head[19:16], 4'b0, head[15:0]};
    end else begin
      event_d = {1'b0, ovf_q, 30'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_s1_q   <= '1;
      key_s2_q   <= '1;
      key_acc_q  <= '1;
      key_prev_q <= '1;
      key_cnt_q  <= '0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      tick_q     <= '0;
      ts_q       <= '0;
      seq_q      <= '0;
      ovf_q      <= 1'b0;
      mem_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      host_q     <= '0;
      status_q   <= '0;
      event_q    <= '0;
    end else begin
      key_s1_q   <= key_s1_d;
      key_s2_q   <= key_s2_d;
      key_acc_q  <= key_acc_d;
      key_prev_q <= key_prev_d;
      key_cnt_q  <= key_cnt_d;
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s2_d;
      tick_q     <= tick_d;
      ts_q       <= ts_d;
      seq_q      <= seq_d;
      ovf_q      <= ovf_d;
      mem_q      <= mem_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      host_q     <= host_d;
      status_q   <= status_d;
      event_q    <= event_d;
    end
  end

  assign status_o = status_q;
  assign event_o  = event_q;

endmodule

// File: tb/tb_pio_input_event_reporter.sv
// Bench for pio_input_event_reporter: random and directed stimulus
// against a queue/window reference model; second instance covers timestamp wrap.
`timescale 1ns/1ps
module tb_pio_input_event_reporter;

  localparam int TICK  = 8;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        rst2;
  logic [3:0]  key_n;
  logic [3:0]  key2_n;
  logic [17:0] sw;
  logic [17:0] sw2;
  logic [31:0] host;
  logic [31:0] host2;
  logic [31:0] status_o;
  logic [31:0] event_o;
  logic [31:0] status2;
  logic [31:0] event2;
  logic        chk_on;
  int          n_chk;
  int          n_err;
  int          cnt2;

  pio_input_event_reporter #(
    .NUM_KEYS(4), .NUM_SW(18), .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES(TICK), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(rst), .key_n_i(key_n), .sw_i(sw),
    .host_ctrl_i(host), .status_o(status_o), .event_o(event_o)
  );

  pio_input_event_reporter #(
    .NUM_KEYS(4), .NUM_SW(18), .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES(1), .FIFO_DEPTH(DEPTH)
  ) dut2 (
    .clk(clk), .reset(rst2), .key_n_i(key2_n), .sw_i(sw2),
    .host_ctrl_i(host2), .status_o(status2), .event_o(event2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst2) cnt2 <= 0;
    else cnt2 <= cnt2 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [5:0]  seq;
    logic [3:0]  mask;
    logic [15:0] ts;
  } ev_t;

  ev_t         m_fifo[$];
  logic [3:0]  m_r1, m_r2, m_pressed, m_pend;
  logic [3:0]  m_win [4];
  logic [17:0] m_w1, m_w2;
  logic        m_ovf;
  logic [1:0]  m_hprev;
  int          m_seq, m_n;
  logic [31:0] exp_status, exp_event;

  task automatic model_edge();
    logic [3:0]  newp;
    logic [15:0] ts_now;
    logic        pop, fl;
    ev_t         e;
    int          sz;
    sz = m_fifo.size();
    exp_status = {m_pressed, 4'(sz), m_ovf, 5'b0, m_w2};
    if (sz != 0) begin
      e = m_fifo[0];
      exp_event = {1'b1, m_ovf, e.seq, e.mask, 4'b0, e.ts};
    end else begin
      exp_event = {1'b0, m_ovf, 30'b0};
    end
    ts_now = 16'((m_n / TICK) % 65536);
    pop = (host[0] != m_hprev[0]);
    fl  = host[1] && !m_hprev[1];
    if (fl) begin
      m_fifo.delete();
      m_ovf = 1'b0;
    end else begin
      if (pop && m_fifo.size() > 0) void'(m_fifo.pop_front());
      if (m_pend != 4'd0) begin
        if (m_fifo.size() < DEPTH) begin
          e.seq  = 6'(m_seq);
          e.mask = m_pend;
          e.ts   = ts_now;
          m_fifo.push_back(e);
          m_seq = (m_seq + 1) % 64;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    m_hprev = host[1:0];
    newp = 4'd0;
    for (int k = 0; k < 4; k++) begin
      m_win[k] = {m_win[k][2:0], ~m_r2[k]};
      if (m_win[k] == {4{~m_pressed[k]}}) begin
        m_pressed[k] = ~m_pressed[k];
        if (m_pressed[k]) newp[k] = 1'b1;
      end
    end
    m_pend = newp;
    m_r2 = m_r1;
    m_r1 = key_n;
    m_w2 = m_w1;
    m_w1 = sw;
    m_n++;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fifo.delete();
      m_r1 = '1;
      m_r2 = '1;
      m_pressed = '0;
      m_pend = '0;
      for (int k = 0; k < 4; k++) m_win[k] = '0;
      m_w1 = '0;
      m_w2 = '0;
      m_ovf = 1'b0;
      m_hprev = '0;
      m_seq = 0;
      m_n = 0;
      exp_status = '0;
      exp_event = '0;
    end else begin
      model_edge();
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("status", status_o, exp_status);
      check("event", event_o, exp_event);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pop1();
    host[0] = ~host[0];
    step(1);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    chk_on = 1'b0;
    rst = 1'b1;
    rst2 = 1'b1;
    key_n = '1;
    key2_n = '1;
    sw = '0;
    sw2 = '0;
    host = '0;
    host2 = '0;
    #1 chk_on = 1'b1;
    step(3);
    check("rst_status", status_o, 32'h0);
    check("rst_event", event_o, 32'h0);
    rst = 1'b0;
    rst2 = 1'b0;
    step(2);

    // single press on key 2
    key_n[2] = 1'b0;
    step(10);
    key_n[2] = 1'b1;
    check("single_pressed", 32'(status_o[30]), 32'd1);
    check("single_valid", 32'(event_o[31]), 32'd1);
    check("single_seq", 32'(event_o[29:24]), 32'd0);
    check("single_mask", 32'(event_o[23:20]), 32'h4);
    step(8);
    pop1();
    step(1);
    check("pop_empty", 32'(event_o[31]), 32'd0);

    // 3-cycle glitch must not be accepted
    key_n[0] = 1'b0;
    step(3);
    key_n[0] = 1'b1;
    step(10);
    check("glitch_key", 32'(status_o[28]), 32'd0);
    check("glitch_evt", 32'(event_o[31]), 32'd0);

    // keys 0 and 3 together
    key_n = 4'b0110;
    step(10);
    check("simul_mask", 32'(event_o[23:20]), 32'h9);
    check("simul_seq", 32'(event_o[29:24]), 32'd1);
    check("simul_cnt", 32'(status_o[27:24]), 32'd1);
    key_n = '1;
    step(8);
    pop1();
    step(2);

    // reset in the middle of a debounce
    key_n[1] = 1'b0;
    step(3);
    rst = 1'b1;
    #1;
    check("midrst_status", status_o, 32'h0);
    check("midrst_event", event_o, 32'h0);
    step(2);
    rst = 1'b0;
    step(3);
    check("post_rst_key", 32'(status_o[29]), 32'd0);
    check("post_rst_evt", event_o, 32'h0);
    step(10);
    check("post_rst_press", 32'(status_o[29]), 32'd1);
    check("post_rst_mask", 32'(event_o[23:20]), 32'h2);
    check("post_rst_seq", 32'(event_o[29:24]), 32'd0);
    key_n = '1;
    step(8);
    pop1();
    step(2);

    // overflow: five presses into a 4-deep FIFO
    for (int i = 0; i < 5; i++) begin
      key_n[0] = 1'b0;
      step(6);
      key_n[0] = 1'b1;
      step(6);
    end
    step(4);
    check("ovf_cnt", 32'(status_o[27:24]), 32'd4);
    check("ovf_stat", 32'(status_o[23]), 32'd1);
    check("ovf_evt", 32'(event_o[30]), 32'd1);
    check("ovf_head", 32'(event_o[29:24]), 32'd1);

    // push and pop in the same cycle while full
    key_n[0] = 1'b0;
    step(6);
    host[0] = ~host[0];
    step(1);
    key_n[0] = 1'b1;
    step(8);
    check("pp_cnt", 32'(status_o[27:24]), 32'd4);
    check("pp_head", 32'(event_o[29:24]), 32'd2);

    // flush
    host[1] = 1'b1;
    step(1);
    host[1] = 1'b0;
    step(2);
    check("flush_stat", 32'(status_o[27:23]), 32'd0);
    check("flush_evt", event_o, 32'h0);

    // sequence number wrap
    for (int i = 0; i < 64; i++) begin
      key_n[3] = 1'b0;
      step(6);
      key_n[3] = 1'b1;
      step(3);
      check("seq_wrap", 32'(event_o[29:24]), 32'((6 + i) % 64));
      pop1();
      step(8);
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      key_n = 4'($urandom);
      sw = 18'($urandom);
      if ($urandom_range(0, 3) == 0) host[0] = ~host[0];
      host[1] = ($urandom_range(0, 19) == 0);
      step($urandom_range(1, 8));
    end
    key_n = '1;
    host[1] = 1'b0;
    step(20);

    // timestamp wrap on the TICK_CYCLES=1 instance
    for (int g = 0; g < 70000 && cnt2 < 65529; g++) step(1);
    check("t2_align", 32'(cnt2), 32'd65529);
    key2_n[0] = 1'b0;
    step(1);
    key2_n[1] = 1'b0;
    step(1);
    for (int g = 0; g < 20 && cnt2 < 65537; g++) step(1);
    check("ts_ffff", event2,
          {1'b1, 1'b0, 6'd0, 4'h1, 4'h0, 16'((65530 + 5) % 65536)});
    host2[0] = 1'b1;
    step(2);
    check("ts_0000", event2,
          {1'b1, 1'b0, 6'd1, 4'h2, 4'h0, 16'((65531 + 5) % 65536)});
    check("ts_cnt", 32'(status2[27:24]), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    n_chk++;
    n_err++;
    $display("FAIL watchdog: got no end of test, required end before time limit");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
